fp_alu_scheduler: RTL and testbench

// - Shares one floating_point_ALU instance between two requesters (e.g. FP issue port and FP load/convert port).
// - Round-robin arbitration; one operation in flight at a time.
// - Holds ALU operands/opcode stable for a per-opcode multicycle window, then captures result + exception flags.
// - Returns the response with the requester id and keeps a sticky exception-flag register (FCSR-style).

---
 rtl/fp_alu_pkg.sv | 28 ++
 rtl/fp_alu_scheduler_if.sv | 44 ++++
 rtl/fp_rr_arbiter2.sv | 37 +++
 rtl/fp_alu_scheduler.sv | 136 +++++++++++++
 tb/tb_fp_alu_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_alu_pkg.sv
// Shared opcode encodings, exception-flag bit positions and scheduler state type
// for the floating-point ALU scheduler.
package fp_alu_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_RND = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_INV = 3'd7;

  // Bit positions inside alu_flags / rsp_flags / flags_sticky
  localparam int FLG_DZ   = 0;
  localparam int FLG_QNAN = 1;
  localparam int FLG_SNAN = 2;
  localparam int FLG_INX  = 3;
  localparam int FLG_UF   = 4;
  localparam int FLG_OF   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fp_alu_scheduler_if.sv
// Bundle of requester, ALU and response signals around the shared FP ALU.
// master = requesters/ALU/consumer side, slave = the scheduler.
interface fp_alu_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] alu_input1;
  logic [31:0] alu_input2;
  logic [2:0]  alu_operation;
  logic [31:0] alu_result;
  logic [5:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [5:0]  rsp_flags;
  logic [5:0]  flags_sticky;
  logic        flags_clear;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_flags, rsp_ready, flags_clear,
    input  req0_ready, req1_ready,
    input  alu_input1, alu_input2, alu_operation,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags_sticky
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_flags, rsp_ready, flags_clear,
    output req0_ready, req1_ready,
    output alu_input1, alu_input2, alu_operation,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, flags_sticky
  );
endinterface

// File: rtl/fp_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one
// that did not win last; last_grant advances only when i_update is asserted.
module fp_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  logic r_last_grant;

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned and infers a latch.
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = 1'b0;
    unique case (i_req)
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = ~r_last_grant;
      default: o_grant_id = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= o_grant_id;
    end
  end

endmodule

// File: rtl/fp_alu_scheduler.sv
// Shares one FP ALU between two requesters: round-robin grant, per-opcode
// hold window on the ALU inputs, response capture and sticky exception flags.
module fp_alu_scheduler
  import fp_alu_pkg::*;
#(
  parameter int LAT_ADD   = 2,
  parameter int LAT_MUL   = 3,
  parameter int LAT_DIV   = 12,
  parameter int LAT_OTHER = 1
) (
  input logic                clk,
  input logic                reset,
  fp_alu_scheduler_if.slave  bus
);

  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_DO  = (LAT_DIV > LAT_OTHER) ? LAT_DIV : LAT_OTHER;
  localparam int LAT_MAX = (LAT_AM > LAT_DO) ? LAT_AM : LAT_DO;
  localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

  sched_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_lat_load;
  logic [2:0]       r_op, w_sel_op;
  logic [31:0]      r_a, r_b, w_sel_a, w_sel_b;
  logic             r_id;
  logic             r_rsp_id;
  logic [31:0]      r_rsp_result;
  logic [5:0]       r_rsp_flags, r_sticky;
  logic             w_grant_valid, w_grant_id, w_accept, w_capture;

  fp_rr_arbiter2 u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_req         ({bus.req1_valid, bus.req0_valid}),
    .i_update      (w_accept),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_comb begin
    w_sel_op = w_grant_id ? bus.req1_op : bus.req0_op;
    w_sel_a  = w_grant_id ? bus.req1_a  : bus.req0_a;
    w_sel_b  = w_grant_id ? bus.req1_b  : bus.req0_b;
  end

  // Counter is loaded with LAT-1 so capture happens in the LAT-th EXEC cycle.
  always_comb begin
    w_lat_load = CNT_W'(LAT_OTHER - 1);
    unique case (w_sel_op)
      OP_ADD, OP_SUB: w_lat_load = CNT_W'(LAT_ADD - 1);
      OP_MUL:         w_lat_load = CNT_W'(LAT_MUL - 1);
      OP_DIV:         w_lat_load = CNT_W'(LAT_DIV - 1);
      default:        w_lat_load = CNT_W'(LAT_OTHER - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the latched operand registers carry no reset; they are only ever
  // observed through outputs gated by the state, which is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op <= w_sel_op;
      r_a  <= w_sel_a;
      r_b  <= w_sel_b;
      r_id <= w_grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_sticky     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_lat_load;
      end else if (r_state == S_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= bus.alu_result;
        r_rsp_flags  <= bus.alu_flags;
        // A clear coinciding with capture keeps only the new flags.
        r_sticky     <= (bus.flags_clear ? 6'd0 : r_sticky) | bus.alu_flags;
      end else if (bus.flags_clear) begin
        r_sticky <= '0;
      end
    end
  end

  assign bus.req0_ready    = (r_state == S_IDLE) && w_grant_valid && !w_grant_id;
  assign bus.req1_ready    = (r_state == S_IDLE) && w_grant_valid &&  w_grant_id;
  assign bus.alu_input1    = (r_state == S_EXEC) ? r_a  : 32'd0;
  assign bus.alu_input2    = (r_state == S_EXEC) ? r_b  : 32'd0;
  assign bus.alu_operation = (r_state == S_EXEC) ? r_op : 3'd0;
  assign bus.rsp_valid     = (r_state == S_RESP);
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_flags     = r_rsp_flags;
  assign bus.flags_sticky  = r_sticky;

endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Directed bench for fp_alu_scheduler with a behavioural single-precision ALU
// model; expected values are hand-computed IEEE-754 constants.
module tb_fp_alu_scheduler;
  import fp_alu_pkg::*;

  localparam logic [31:0] F1  = 32'h3F800000;  // 1.0
  localparam logic [31:0] F2  = 32'h40000000;  // 2.0
  localparam logic [31:0] F3  = 32'h40400000;  // 3.0
  localparam logic [31:0] F6  = 32'h40C00000;  // 6.0
  localparam logic [31:0] FM1 = 32'hBF800000;  // -1.0
  localparam logic [31:0] INF = 32'h7F800000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_alu_scheduler_if bus ();

  fp_alu_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single precision <-> real, normals and zero only.
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  always_comb begin
    bus.alu_result = 32'd0;
    bus.alu_flags  = 6'd0;
    unique case (bus.alu_operation)
      OP_ADD: bus.alu_result = r2sp(sp2r(bus.alu_input1) + sp2r(bus.alu_input2));
      OP_SUB: bus.alu_result = r2sp(sp2r(bus.alu_input1) - sp2r(bus.alu_input2));
      OP_MUL: bus.alu_result = r2sp(sp2r(bus.alu_input1) * sp2r(bus.alu_input2));
      OP_DIV: begin
        if (bus.alu_input2[30:0] == 31'd0) begin
          bus.alu_result        = INF;
          bus.alu_flags[FLG_DZ] = 1'b1;
        end else begin
          bus.alu_result = r2sp(sp2r(bus.alu_input1) / sp2r(bus.alu_input2));
        end
      end
      OP_RND: bus.alu_result = bus.alu_input1;
      OP_SLT: bus.alu_result = {31'd0, sp2r(bus.alu_input1) < sp2r(bus.alu_input2)};
      OP_INV: bus.alu_result = bus.alu_input1 ^ 32'h80000000;
      default: bus.alu_result = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Present an op, wait (bounded) for ready, complete the handshake, drop valid.
  task automatic issue(input string tag, input bit id, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    drive_req(id, 1'b1, op, a, b);
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
      tick();
      #1;
      n++;
    end
    check({tag, "_accept"}, 32'(n < 50), 32'd1);
    tick();
    drive_req(id, 1'b0, op, a, b);
  endtask

  // Entered just after the handshake edge; counts edges until rsp_valid and
  // watches the ALU drive and the ready lines during EXEC.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int k;
    int bad;
    k   = 0;
    bad = 0;
    while (!bus.rsp_valid && k < 40) begin
      if (bus.alu_operation !== op || bus.alu_input1 !== a || bus.alu_input2 !== b ||
          bus.req0_ready || bus.req1_ready) bad++;
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_exec_hold"}, 32'(bad), 32'd0);
    check({tag, "_alu_idle"}, bus.alu_input1 | bus.alu_input2 | 32'(bus.alu_operation), 32'd0);
  endtask

  task automatic take_rsp(input string tag, input bit id, input logic [31:0] res,
                          input logic [5:0] flg);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_result"}, bus.rsp_result, res);
    check({tag, "_flags"}, 32'(bus.rsp_flags), 32'(flg));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_result_kept"}, bus.rsp_result, res);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          bad;
    int          n;
    bit          g;

    reset = 1'b1;
    drive_req(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0);
    bus.rsp_ready   = 1'b0;
    bus.flags_clear = 1'b0;
    repeat (3) tick();

    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_sticky", 32'(bus.flags_sticky), 32'd0);
    check("rst_alu_op", 32'(bus.alu_operation), 32'd0);
    reset = 1'b0;
    tick();

    // ADD from requester 0
    issue("add", 1'b0, OP_ADD, F1, F2);
    wait_rsp("add", 2, OP_ADD, F1, F2);
    take_rsp("add", 1'b0, F3, 6'd0);

    // SLT from requester 1
    issue("slt", 1'b1, OP_SLT, F1, F2);
    wait_rsp("slt", 1, OP_SLT, F1, F2);
    take_rsp("slt", 1'b1, 32'd1, 6'd0);

    // Both requesters held valid: strict alternation starting with 0
    drive_req(1'b0, 1'b1, OP_ADD, F1, F2);
    drive_req(1'b1, 1'b1, OP_SUB, F2, F1);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 50) begin
        tick();
        #1;
        n++;
      end
      g = bus.req1_ready;
      check("rr_grant_id", 32'(g), 32'(i % 2));
      check("rr_one_grant", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      tick();
      if (g) begin
        wait_rsp("rr_sub", 2, OP_SUB, F2, F1);
        take_rsp("rr_sub", 1'b1, F1, 6'd0);
      end else begin
        wait_rsp("rr_add", 2, OP_ADD, F1, F2);
        take_rsp("rr_add", 1'b0, F3, 6'd0);
      end
    end
    drive_req(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0);

    // Divide by zero sets DZ, which stays sticky across a clean ADD
    issue("div0", 1'b0, OP_DIV, F1, 32'd0);
    wait_rsp("div0", 12, OP_DIV, F1, 32'd0);
    take_rsp("div0", 1'b0, INF, 6'b000001);
    check("sticky_after_div0", 32'(bus.flags_sticky), 32'h01);
    issue("add2", 1'b0, OP_ADD, F1, F2);
    wait_rsp("add2", 2, OP_ADD, F1, F2);
    take_rsp("add2", 1'b0, F3, 6'd0);
    check("sticky_kept", 32'(bus.flags_sticky), 32'h01);
    bus.flags_clear = 1'b1;
    tick();
    bus.flags_clear = 1'b0;
    check("sticky_cleared", 32'(bus.flags_sticky), 32'd0);

    // Clear arriving in the capture cycle keeps the newly captured flag
    issue("div0c", 1'b1, OP_DIV, F2, 32'd0);
    repeat (11) tick();
    bus.flags_clear = 1'b1;
    tick();
    bus.flags_clear = 1'b0;
    check("clear_at_capture_valid", 32'(bus.rsp_valid), 32'd1);
    check("clear_at_capture_sticky", 32'(bus.flags_sticky), 32'h01);
    take_rsp("div0c", 1'b1, INF, 6'b000001);
    bus.flags_clear = 1'b1;
    tick();
    bus.flags_clear = 1'b0;

    // Response back-pressure: MUL held five cycles with requester 0 waiting
    issue("mul", 1'b1, OP_MUL, F2, F3);
    wait_rsp("mul", 3, OP_MUL, F2, F3);
    drive_req(1'b0, 1'b1, OP_NOP, 32'd0, 32'd0);
    held = bus.rsp_result;
    bad  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_result !== held || bus.rsp_id !== 1'b1 ||
          bus.req0_ready || bus.req1_ready) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    take_rsp("mul", 1'b1, F6, 6'd0);
    check("bp_next_grant", 32'(bus.req0_ready), 32'd1);
    issue("nop", 1'b0, OP_NOP, 32'd0, 32'd0);
    wait_rsp("nop", 1, OP_NOP, 32'd0, 32'd0);
    take_rsp("nop", 1'b0, 32'd0, 6'd0);

    // Opcode 7 uses the short latency path
    issue("inv", 1'b1, OP_INV, F1, F2);
    wait_rsp("inv", 1, OP_INV, F1, F2);
    take_rsp("inv", 1'b1, FM1, 6'd0);

    // Reset in the middle of a DIV aborts it
    issue("divrst", 1'b0, OP_DIV, F6, F2);
    repeat (4) tick();
    check("divrst_in_exec", 32'(bus.alu_operation), 32'(OP_DIV));
    reset = 1'b1;
    tick();
    check("divrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("divrst_alu_zero", bus.alu_input1 | bus.alu_input2 | 32'(bus.alu_operation), 32'd0);
    check("divrst_rsp_result", bus.rsp_result, 32'd0);
    check("divrst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    reset = 1'b0;
    drive_req(1'b0, 1'b1, OP_ADD, F1, F2);
    #1;
    check("post_rst_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    drive_req(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0);
    wait_rsp("post_rst", 2, OP_ADD, F1, F2);
    take_rsp("post_rst", 1'b0, F3, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
